// File: rtl/decoder_pkg.sv
// Shared mode encodings and decode helpers for decoder_pipe.
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'd0;
  localparam logic [1:0] MODE_THERM  = 2'd1;
  localparam logic [1:0] MODE_ACCUM  = 2'd2;
  localparam logic [1:0] MODE_CLEAR  = 2'd3;

  // Widest decode the helpers support; callers cast the result down to OUT_W.
  localparam int MAX_W = 256;

  // Bit k set when k < w; an out-of-range k yields zero.
  function automatic logic [MAX_W-1:0] onehot(input logic [31:0] k, input int unsigned w);
    onehot = '0;
    for (int unsigned i = 0; i < MAX_W; i++) onehot[i] = (i == k) && (i < w);
  endfunction

  // Bits [k:0] set, clipped to w; an out-of-range k saturates to all w bits.
  function automatic logic [MAX_W-1:0] therm(input logic [31:0] k, input int unsigned w);
    therm = '0;
    for (int unsigned i = 0; i < MAX_W; i++) therm[i] = (i <= k) && (i < w);
  endfunction

endpackage

// File: rtl/decoder_pipe_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
// in_ready is registered, so there is no combinational path from out_ready.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_vld;
  logic [W-1:0] skid_dat;
  logic         in_fire;
  logic         out_free;
  logic         skid_vld_nxt;

  assign in_fire      = in_valid & in_ready;
  assign out_free     = ~out_valid | out_ready;
  assign skid_vld_nxt = out_free ? 1'b0 : (skid_vld | in_fire);

  // in_ready high implies the skid entry is empty, so a beat never arrives
  // while the skid entry is being drained into the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
      in_ready  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          out_valid <= 1'b1;
          out_data  <= skid_dat;
        end else begin
          out_valid <= in_fire;
          if (in_fire) out_data <= in_data;
        end
      end else if (in_fire) begin
        skid_dat <= in_data;
      end
      skid_vld <= skid_vld_nxt;
      in_ready <= ~skid_vld_nxt;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined binary decoder: one-hot / thermometer / accumulate / clear per beat,
// with out-of-range flag and a backpressure-safe registered output.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_err
);

  logic [31:0]      k;
  logic             oor;
  logic             in_fire;
  logic [OUT_W-1:0] oh, th;
  logic [OUT_W-1:0] acc, acc_nxt, word;
  logic             err;
  logic [OUT_W:0]   skid_out;

  assign k       = 32'(in_code);
  assign oor     = k >= 32'(OUT_W);
  assign oh      = OUT_W'(onehot(k, OUT_W));
  assign th      = OUT_W'(therm(k, OUT_W));
  assign in_fire = in_valid & in_ready;

  // oh is already zero when out of range, so ACCUM leaves acc untouched then.
  always_comb begin
    word    = '0;
    err     = 1'b0;
    acc_nxt = acc;
    if (en) begin
      case (in_mode)
        MODE_ONEHOT: begin word = oh;       err = oor; end
        MODE_THERM:  begin word = th;       err = oor; end
        MODE_ACCUM:  begin word = acc | oh; err = oor; acc_nxt = acc | oh; end
        MODE_CLEAR:  acc_nxt = '0;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc <= '0;
    else if (in_fire) acc <= acc_nxt;
  end

  skid_buf #(.W(OUT_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({err, word}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  assign out_err = skid_out[OUT_W];
  assign out_bin = skid_out[OUT_W-1:0];

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: directed scenarios plus a randomized
// stream scored against a queue-based reference model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, in_valid, out_ready;
  logic [3:0]  in_code;
  logic [1:0]  in_mode;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_bin;

  logic        en10, v10, ordy10;
  logic [3:0]  code10;
  logic [1:0]  mode10;
  logic        rdy10, ov10, oerr10;
  logic [9:0]  obin10;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic [15:0] m_acc;

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(4), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_err(out_err)
  );

  decoder_pipe #(.IN_W(4), .OUT_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en10), .in_valid(v10), .in_ready(rdy10),
    .in_code(code10), .in_mode(mode10), .out_valid(ov10), .out_ready(ordy10),
    .out_bin(obin10), .out_err(oerr10)
  );

  // Reference model: what each accepted beat should produce, from the mode rules.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
      m_acc = 16'h0;
    end else begin
      if (out_valid && out_ready) obs_q.push_back({out_err, out_bin});
      if (in_valid && in_ready) begin
        int k;
        logic [15:0] w;
        logic e;
        k = int'(in_code);
        w = 16'h0;
        e = 1'b0;
        if (en) begin
          case (in_mode)
            2'd0: begin e = (k >= 16); if (k < 16) w = 16'(1 << k); end
            2'd1: begin e = (k >= 16); w = (k >= 16) ? 16'hFFFF : 16'((1 << (k + 1)) - 1); end
            2'd2: begin e = (k >= 16); if (k < 16) m_acc = m_acc | 16'(1 << k); w = m_acc; end
            default: m_acc = 16'h0;
          endcase
        end
        exp_q.push_back({e, w});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] m, input logic e);
    in_valid = 1'b1; in_code = c; in_mode = m; en = e;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = '0; in_mode = '0; out_ready = 1'b1;
    en10 = 1'b0; v10 = 1'b0; code10 = '0; mode10 = '0; ordy10 = 1'b1;
    step(); step();
    n_cmp++; if ({out_valid, out_err, out_bin} !== 18'h0) begin n_err++;
      $display("FAIL reset_out: got v=%b e=%b bin=%h want 0/0/0000", out_valid, out_err, out_bin); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_onehot();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] want;
      want = 16'h1 << i;
      in_valid = 1'b1; in_code = 4'(i); in_mode = 2'd0; en = 1'b1;
      step();
      n_cmp++; if ({out_valid, out_err, out_bin} !== {2'b10, want}) begin n_err++;
        $display("FAIL onehot_%0d: got v=%b e=%b bin=%h want 1/0/%h", i, out_valid, out_err, out_bin, want); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL onehot_idle: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_therm();
    logic [3:0]  codes[4] = '{4'd5, 4'd0, 4'd15, 4'd7};
    logic        ens[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] wants[4] = '{16'h003F, 16'h0001, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      drive(codes[i], 2'd1, ens[i]);
      n_cmp++; if ({out_valid, out_err, out_bin} !== {2'b10, wants[i]}) begin n_err++;
        $display("FAIL therm_%0d: got v=%b e=%b bin=%h want 1/0/%h", i, out_valid, out_err, out_bin, wants[i]); end
    end
  endtask

  task automatic test_accum();
    logic [3:0]  codes[6] = '{4'd9, 4'd3, 4'd8, 4'd3, 4'd0, 4'd0};
    logic [1:0]  modes[6] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
    logic [15:0] wants[6] = '{16'h0000, 16'h0008, 16'h0108, 16'h0108, 16'h0000, 16'h0001};
    for (int i = 0; i < 6; i++) begin
      drive(codes[i], modes[i], 1'b1);
      n_cmp++; if ({out_valid, out_err, out_bin} !== {2'b10, wants[i]}) begin n_err++;
        $display("FAIL accum_%0d: got v=%b e=%b bin=%h want 1/0/%h", i, out_valid, out_err, out_bin, wants[i]); end
    end
  endtask

  task automatic test_oor();
    logic [3:0] codes[4] = '{4'd12, 4'd12, 4'd2, 4'd12};
    logic [1:0] modes[4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [10:0] wants[4] = '{{1'b1, 10'h000}, {1'b1, 10'h3FF}, {1'b0, 10'h004}, {1'b1, 10'h004}};
    for (int i = 0; i < 4; i++) begin
      v10 = 1'b1; code10 = codes[i]; mode10 = modes[i]; en10 = 1'b1;
      step();
      n_cmp++; if ({ov10, oerr10, obin10} !== {1'b1, wants[i]}) begin n_err++;
        $display("FAIL oor_%0d: got v=%b e=%b bin=%h want 1/%b/%h", i, ov10, oerr10, obin10,
                 wants[i][10], wants[i][9:0]); end
    end
    v10 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    logic rdy;
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step();
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_code = 4'(accepted + 1); in_mode = 2'd0; en = 1'b1;
      rdy = in_ready;
      step();
      if (rdy) accepted++;
      n_cmp++; if ({out_valid, out_bin} !== {1'b1, 16'h0002}) begin n_err++;
        $display("FAIL bp_stable_%0d: got v=%b bin=%h want 1/0002", c, out_valid, out_bin); end
    end
    n_cmp++; if (accepted !== 2 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_ready_drop: got accepted=%0d in_ready=%b want 2/0", accepted, in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && accepted < 4; c++) begin
      in_valid = 1'b1; in_code = 4'(accepted + 1);
      rdy = in_ready;
      step();
      if (rdy) accepted++;
    end
    in_valid = 1'b0;
    n_cmp++; if (accepted != 4) begin n_err++;
      $display("FAIL bp_timeout: got accepted=%0d want 4", accepted); end
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (obs_q.size() != 4) begin n_err++;
      $display("FAIL bp_count: got %0d beats want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      logic [16:0] want;
      want = {1'b0, 16'h1 << (i + 1)};
      n_cmp++; if (obs_q[i] !== want) begin n_err++;
        $display("FAIL bp_order_%0d: got %h want %h", i, obs_q[i], want); end
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step();
    exp_q.delete(); obs_q.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_code   = 4'($urandom_range(0, 15));
      in_mode   = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 9) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() < 100) begin n_err++;
      $display("FAIL rand_count: got %0d beats want %0d (>=100)", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL rand_beat_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] codes[5] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [1:0] modes[5] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(codes[i], modes[i], 1'b1);
    n_cmp++; if (out_bin !== 16'h00F0) begin n_err++;
      $display("FAIL rst_acc_setup: got %h want 00f0", out_bin); end
    out_ready = 1'b0;
    drive(4'd2, 2'd0, 1'b1);
    drive(4'd3, 2'd0, 1'b1);
    rst_n = 1'b0;
    step();
    n_cmp++; if ({out_valid, out_err, out_bin, in_ready} !== 19'h0) begin n_err++;
      $display("FAIL rst_mid_out: got v=%b e=%b bin=%h rdy=%b want all 0", out_valid, out_err, out_bin, in_ready); end
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++;
      $display("FAIL rst_mid_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    drive(4'd0, 2'd2, 1'b1);
    n_cmp++; if (out_bin !== 16'h0001) begin n_err++;
      $display("FAIL rst_mid_acc: got %h want 0001", out_bin); end
    step();
    n_cmp++; if (obs_q.size() != 1) begin n_err++;
      $display("FAIL rst_mid_replay: got %0d beats want 1", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_therm();
    test_accum();
    test_oor();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
